// File: rtl/axis_image_vip_pkg.sv
// Shared helpers for the AXI-Stream image VIP: width ratio and lane-counter sizing.
package axis_image_vip_pkg;

  function automatic int calc_ratio(input int in_bytes, input int out_bytes);
    if (in_bytes <= 0) return 1;
    return out_bytes / in_bytes;
  endfunction

  // A counter for one lane still needs a single bit so the port widths stay legal.
  function automatic int lane_width(input int ratio);
    if (ratio <= 2) return 1;
    return $clog2(ratio);
  endfunction

endpackage

// File: rtl/axis_image_vip_config.svh
// Build-wide defaults for the AXI-Stream image VIP blocks (source and sink beat widths).
`ifndef AXIS_IMAGE_VIP_CONFIG_SVH
`define AXIS_IMAGE_VIP_CONFIG_SVH

`define SOURCE_BYTES 1
`define SINK_BYTES   4

`endif

// File: rtl/axis_width_upsizer.sv
// Packs RATIO narrow AXI-Stream beats into one wide beat, little-endian, early-closing on last.
// Optional byte-keep output is enabled with `define AXIS_UPSIZER_KEEP_EN.
`include "axis_image_vip_config.svh"

module axis_width_upsizer
  import axis_image_vip_pkg::*;
#(
  parameter int INPUT_BYTES  = `SOURCE_BYTES,
  parameter int OUTPUT_BYTES = `SINK_BYTES,
  localparam int INPUT_BITS  = INPUT_BYTES * 8,
  localparam int OUTPUT_BITS = OUTPUT_BYTES * 8,
  localparam int RATIO       = calc_ratio(INPUT_BYTES, OUTPUT_BYTES)
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic [INPUT_BITS-1:0]  axis_s_data_i,
  input  logic                   axis_s_valid_i,
  output logic                   axis_s_ready_o,
  input  logic                   axis_s_last_i,
  input  logic                   axis_s_user_i,
  output logic [OUTPUT_BITS-1:0] axis_m_data_o,
  output logic                   axis_m_valid_o,
  input  logic                   axis_m_ready_i,
  output logic                   axis_m_last_o,
  output logic                   axis_m_user_o
`ifdef AXIS_UPSIZER_KEEP_EN
  ,
  output logic [OUTPUT_BYTES-1:0] axis_m_keep_o
`endif
);

  localparam int LANE_W = lane_width(RATIO);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

  if ((OUTPUT_BYTES < INPUT_BYTES) || ((OUTPUT_BYTES % INPUT_BYTES) != 0)) begin : g_bad_ratio
    $error("axis_width_upsizer: OUTPUT_BYTES must be an integer multiple of INPUT_BYTES");
  end

  logic [LANE_W-1:0]      lane_q;
  logic [OUTPUT_BITS-1:0] pack_q;
  logic                   user_q;
  logic [OUTPUT_BITS-1:0] word_c;
  logic                   word_user;
  logic                   out_free;
  logic                   s_accept;
  logic                   completing;

  assign out_free       = !axis_m_valid_o || axis_m_ready_i;
  assign completing     = (lane_q == LAST_LANE) || axis_s_last_i;
  assign axis_s_ready_o = out_free || ((lane_q != LAST_LANE) && !axis_s_last_i);
  assign s_accept       = axis_s_valid_i && axis_s_ready_o;
  assign word_user      = (lane_q == '0) ? axis_s_user_i : user_q;

  // The pack register is cleared whenever a word leaves, so unfilled upper lanes read as zero.
  always_comb begin
    word_c = pack_q;
    word_c[int'(lane_q)*INPUT_BITS +: INPUT_BITS] = axis_s_data_i;
  end

`ifdef AXIS_UPSIZER_KEEP_EN
  logic [OUTPUT_BYTES-1:0] keep_c;

  always_comb begin
    keep_c = '0;
    for (int b = 0; b < OUTPUT_BYTES; b++) begin
      keep_c[b] = ((b / INPUT_BYTES) <= int'(lane_q));
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      lane_q         <= '0;
      pack_q         <= '0;
      user_q         <= 1'b0;
      axis_m_data_o  <= '0;
      axis_m_valid_o <= 1'b0;
      axis_m_last_o  <= 1'b0;
      axis_m_user_o  <= 1'b0;
`ifdef AXIS_UPSIZER_KEEP_EN
      axis_m_keep_o  <= '0;
`endif
    end else begin
      if (axis_m_valid_o && axis_m_ready_i) begin
        axis_m_valid_o <= 1'b0;
      end
      // A completing beat can only be accepted while the output slot is free.
      if (s_accept) begin
        if (completing) begin
          axis_m_data_o  <= word_c;
          axis_m_valid_o <= 1'b1;
          axis_m_last_o  <= axis_s_last_i;
          axis_m_user_o  <= word_user;
`ifdef AXIS_UPSIZER_KEEP_EN
          axis_m_keep_o  <= keep_c;
`endif
          lane_q         <= '0;
          pack_q         <= '0;
        end else begin
          pack_q <= word_c;
          lane_q <= lane_q + 1'b1;
          if (lane_q == '0) begin
            user_q <= axis_s_user_i;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_width_upsizer.sv
// Directed self-checking bench for axis_width_upsizer at 1-byte in, 4-byte out.
module tb_axis_width_upsizer;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        s_last;
  logic        s_user;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        m_user;
`ifdef AXIS_UPSIZER_KEEP_EN
  logic [3:0]  m_keep;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axis_width_upsizer #(
    .INPUT_BYTES (1),
    .OUTPUT_BYTES(4)
  ) dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .axis_s_data_i (s_data),
    .axis_s_valid_i(s_valid),
    .axis_s_ready_o(s_ready),
    .axis_s_last_i (s_last),
    .axis_s_user_i (s_user),
    .axis_m_data_o (m_data),
    .axis_m_valid_o(m_valid),
    .axis_m_ready_i(m_ready),
    .axis_m_last_o (m_last),
    .axis_m_user_o (m_user)
`ifdef AXIS_UPSIZER_KEEP_EN
    ,
    .axis_m_keep_o (m_keep)
`endif
  );

  typedef struct {
    logic        valid;
    logic [7:0]  data;
    logic        last;
    logic        user;
    logic        m_rdy;
    logic        exp_s_ready;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_last;
    logic        exp_user;
    logic [3:0]  exp_keep;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic l, input logic u,
                              input logic mr, input logic esr, input logic ev,
                              input logic [31:0] ed, input logic el, input logic eu,
                              input logic [3:0] ek);
    vec_t t;
    t.valid = v; t.data = d; t.last = l; t.user = u; t.m_rdy = mr;
    t.exp_s_ready = esr; t.exp_valid = ev; t.exp_data = ed;
    t.exp_last = el; t.exp_user = eu; t.exp_keep = ek;
    return t;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic u,
                       input logic mr);
    s_valid = v; s_data = d; s_last = l; s_user = u; m_ready = mr;
  endtask

  // Inputs change 1 time unit after a rising edge; s_ready is sampled mid-cycle.
  task automatic apply_stimulus(input vec_t t, input int idx);
    drive(t.valid, t.data, t.last, t.user, t.m_rdy);
    #3;
    check_output($sformatf("vec%0d_s_ready", idx), 32'(s_ready), 32'(t.exp_s_ready));
    @(posedge clk);
    #1;
    check_output($sformatf("vec%0d_m_valid", idx), 32'(m_valid), 32'(t.exp_valid));
    if (t.exp_valid) begin
      check_output($sformatf("vec%0d_m_data", idx), m_data, t.exp_data);
      check_output($sformatf("vec%0d_m_last", idx), 32'(m_last), 32'(t.exp_last));
      check_output($sformatf("vec%0d_m_user", idx), 32'(m_user), 32'(t.exp_user));
`ifdef AXIS_UPSIZER_KEEP_EN
      check_output($sformatf("vec%0d_m_keep", idx), 32'(m_keep), 32'(t.exp_keep));
`endif
    end
  endtask

  initial begin
    int words;
    int last_cycle;
    logic s_ready_seen_low;

    // Full word, early last, then backpressure on a held word.
    vecs[0]  = mk(1, 8'h11, 0, 1, 1, 1, 0, 32'h0,        0, 0, 4'h0);
    vecs[1]  = mk(1, 8'h22, 0, 0, 1, 1, 0, 32'h0,        0, 0, 4'h0);
    vecs[2]  = mk(1, 8'h33, 0, 0, 1, 1, 0, 32'h0,        0, 0, 4'h0);
    vecs[3]  = mk(1, 8'h44, 1, 0, 1, 1, 1, 32'h44332211, 1, 1, 4'hF);
    vecs[4]  = mk(0, 8'h00, 0, 0, 1, 1, 0, 32'h0,        0, 0, 4'h0);
    vecs[5]  = mk(1, 8'hAA, 0, 0, 1, 1, 0, 32'h0,        0, 0, 4'h0);
    vecs[6]  = mk(1, 8'hBB, 1, 0, 1, 1, 1, 32'h0000BBAA, 1, 0, 4'h3);
    vecs[7]  = mk(0, 8'h00, 0, 0, 1, 1, 0, 32'h0,        0, 0, 4'h0);
    vecs[8]  = mk(1, 8'h01, 0, 1, 1, 1, 0, 32'h0,        0, 0, 4'h0);
    vecs[9]  = mk(1, 8'h02, 0, 0, 1, 1, 0, 32'h0,        0, 0, 4'h0);
    vecs[10] = mk(1, 8'h03, 0, 0, 1, 1, 0, 32'h0,        0, 0, 4'h0);
    vecs[11] = mk(1, 8'h04, 1, 0, 1, 1, 1, 32'h04030201, 1, 1, 4'hF);
    vecs[12] = mk(1, 8'h05, 0, 0, 0, 1, 1, 32'h04030201, 1, 1, 4'hF);
    vecs[13] = mk(1, 8'h06, 0, 0, 0, 1, 1, 32'h04030201, 1, 1, 4'hF);
    vecs[14] = mk(1, 8'h07, 0, 0, 0, 1, 1, 32'h04030201, 1, 1, 4'hF);
    vecs[15] = mk(1, 8'h08, 0, 0, 0, 0, 1, 32'h04030201, 1, 1, 4'hF);
    vecs[16] = mk(1, 8'h08, 0, 0, 1, 1, 1, 32'h08070605, 0, 0, 4'hF);
    vecs[17] = mk(0, 8'h00, 0, 0, 1, 1, 0, 32'h0,        0, 0, 4'h0);

    rstn = 1'b0;
    drive(0, 8'h00, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_m_valid", 32'(m_valid), 32'h0);
    check_output("rst_m_data", m_data, 32'h0);
    check_output("rst_m_last", 32'(m_last), 32'h0);
    check_output("rst_m_user", 32'(m_user), 32'h0);
    check_output("rst_s_ready", 32'(s_ready), 32'h1);
`ifdef AXIS_UPSIZER_KEEP_EN
    check_output("rst_m_keep", 32'(m_keep), 32'h0);
`endif
    rstn = 1'b1;

    for (int i = 0; i < 18; i++) begin
      apply_stimulus(vecs[i], i);
    end

    // Reset in the middle of a word discards the partial lanes.
    drive(1, 8'h55, 0, 1, 1);
    @(posedge clk); #1;
    drive(1, 8'h66, 0, 0, 1);
    @(posedge clk); #1;
    drive(0, 8'h00, 0, 0, 1);
    rstn = 1'b0;
    @(posedge clk); #1;
    check_output("midrst_m_valid", 32'(m_valid), 32'h0);
    check_output("midrst_m_data", m_data, 32'h0);
    check_output("midrst_m_last", 32'(m_last), 32'h0);
    check_output("midrst_m_user", 32'(m_user), 32'h0);
    check_output("midrst_s_ready", 32'(s_ready), 32'h1);
    rstn = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1, 8'(i), (i == 4), (i == 1), 1);
      @(posedge clk); #1;
    end
    drive(0, 8'h00, 0, 0, 1);
    check_output("midrst_word_valid", 32'(m_valid), 32'h1);
    check_output("midrst_word_data", m_data, 32'h04030201);
    check_output("midrst_word_user", 32'(m_user), 32'h1);
    @(posedge clk); #1;
    check_output("midrst_drain_valid", 32'(m_valid), 32'h0);

    // Sustained throughput: one word every 4 cycles, s_ready never drops.
    words = 0;
    last_cycle = -1;
    s_ready_seen_low = 1'b0;
    for (int i = 0; i < 64; i++) begin
      drive(1, 8'(i), 0, (i % 4 == 0), 1);
      #3;
      if (!s_ready) s_ready_seen_low = 1'b1;
      @(posedge clk); #1;
      if (m_valid) begin
        check_output($sformatf("tput_word%0d_data", words), m_data,
                     {8'(4*words+3), 8'(4*words+2), 8'(4*words+1), 8'(4*words)});
        check_output($sformatf("tput_word%0d_cycle", words), 32'(i), 32'(4*words+3));
        if (last_cycle >= 0) begin
          check_output($sformatf("tput_word%0d_gap", words), 32'(i - last_cycle), 32'd4);
        end
        last_cycle = i;
        words++;
      end
    end
    drive(0, 8'h00, 0, 0, 1);
    check_output("tput_s_ready_low", 32'(s_ready_seen_low), 32'h0);
    check_output("tput_word_count", 32'(words), 32'd16);
    @(posedge clk); #1;
    check_output("tput_drain_valid", 32'(m_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_width_upsizer.md
AXIS_WIDTH_UPSIZER -- requirements
Module: axis_width_upsizer

Interface
REQ-001 SHALL have parameter INPUT_BYTES, default `SOURCE_BYTES, slave beat width in bytes.
REQ-002 SHALL have parameter OUTPUT_BYTES, default `SINK_BYTES, master beat width in bytes.
REQ-003 SHALL have parameters INPUT_BITS = INPUT_BYTES*8, OUTPUT_BITS = OUTPUT_BYTES*8, and RATIO = OUTPUT_BYTES/INPUT_BYTES (derived, not overridden).
REQ-004 SHALL have port clk_i, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port rstn_i, input, 1, reset that is synchronous and active-low.
REQ-006 SHALL have port axis_s_data_i, input, INPUT_BITS, slave pixel data.
REQ-007 SHALL have ports axis_s_valid_i (input, 1), axis_s_ready_o (output, 1), axis_s_last_i (input, 1, end of line) and axis_s_user_i (input, 1, start of frame).
REQ-008 SHALL have port axis_m_data_o, output, OUTPUT_BITS, packed data.
REQ-009 SHALL have ports axis_m_valid_o (output, 1), axis_m_ready_i (input, 1), axis_m_last_o (output, 1) and axis_m_user_o (output, 1).

Function
REQ-010 SHALL define a slave beat as accepted when axis_s_valid_i and axis_s_ready_o are both 1, and a master beat as transferred when axis_m_valid_o and axis_m_ready_i are both 1.
REQ-011 SHALL pack accepted beats little-endian: the lane counter (0..RATIO-1, reset 0) selects the lane, and lane k occupies bits [k*INPUT_BITS +: INPUT_BITS].
REQ-012 SHALL treat a beat as completing when the lane counter equals RATIO-1 or axis_s_last_i=1.
REQ-013 SHALL, on accepting a completing beat, load the output register at the next edge with the packed word, set axis_m_valid_o, and reset the lane counter to 0.
REQ-014 SHALL zero-fill unused upper lanes of a word completed early by last.
REQ-015 SHALL drive axis_m_data_o from the output register only, with latency one cycle from acceptance of the completing beat.
REQ-016 SHALL drive axis_m_user_o from the user bit of the lane-0 beat of that word, and axis_m_last_o from the last bit of the completing beat.
REQ-017 SHALL increment the lane counter on accepting a non-completing beat and write only that lane of the pack register.
REQ-018 SHALL compute out_free = !axis_m_valid_o || axis_m_ready_i.
REQ-019 SHALL drive axis_s_ready_o = out_free || (lane counter != RATIO-1 && !axis_s_last_i).
REQ-020 SHALL sustain, with both sides always ready, one master beat every RATIO cycles with axis_s_ready_o constantly 1, including back-to-back words where a transfer and a new load occur in the same cycle.
REQ-021 SHALL clear axis_m_valid_o after a transfer unless a new completing beat is accepted in the same cycle.
REQ-022 SHALL hold axis_m_data_o, axis_m_last_o and axis_m_user_o stable while axis_m_valid_o=1 and axis_m_ready_i=0.
REQ-023 SHALL, when RATIO=1, behave as a single register slice with latency 1.
REQ-024 SHALL abort elaboration with $error if OUTPUT_BYTES is not an integer multiple of INPUT_BYTES.

Reset
REQ-025 SHALL, while rstn_i=0 at an edge, clear the lane counter, the pack register, the output register data, axis_m_valid_o, axis_m_last_o and axis_m_user_o to 0.
REQ-026 SHALL, on reset mid-word, discard the partial word so that the first beat after reset lands in lane 0.
REQ-027 SHALL hold axis_s_ready_o at 1 after reset, since the output register is empty.

Configuration
REQ-028 SHALL, with macro AXIS_UPSIZER_KEEP_EN defined, add output port axis_m_keep_o of OUTPUT_BYTES bits, with a 1 for each byte belonging to a filled lane (all ones for a full word) and a reset value of 0.
REQ-029 SHALL, without AXIS_UPSIZER_KEEP_EN, omit axis_m_keep_o and its logic, with all other behaviour identical.

Structure
REQ-030 SHALL take SOURCE_BYTES/SINK_BYTES defaults from axis_image_vip_config.svh; the lane-counter width function and the RATIO computation SHALL reside in shared package axis_image_vip_pkg.
REQ-031 SHALL be a single module with no sub-module; the pack register and output register are inline.

Verification (INPUT_BYTES=1, OUTPUT_BYTES=4 unless noted)
REQ-032 SHALL cover a full word: beats 0x11, 0x22, 0x33, 0x44 with user on the first beat, last on the fourth beat and axis_m_ready_i=1 -> the next cycle gives axis_m_data_o=0x44332211, user=1, last=1, valid for exactly one cycle.
REQ-033 SHALL cover early last: beats 0xAA, then 0xBB with last=1 -> axis_m_data_o=0x0000BBAA, last=1, and keep=4'b0011 when AXIS_UPSIZER_KEEP_EN is defined.
REQ-034 SHALL cover backpressure: axis_m_ready_i=0 after the first word with continuous input -> three further beats accepted, axis_s_ready_o=0 at the fourth beat, first word held stable, and acceptance resuming in the cycle axis_m_ready_i returns to 1.
REQ-035 SHALL cover reset mid-word: rstn_i=0 after two accepted beats -> all outputs 0 and axis_s_ready_o=1; the next four beats 0x01..0x04 give 0x04030201.
REQ-036 SHALL cover throughput: 64 continuous beats with ready held at 1 -> 16 master beats at a 4-cycle spacing and axis_s_ready_o never 0.
REQ-037 SHALL cover the illegal configuration INPUT_BYTES=2, OUTPUT_BYTES=3 -> elaboration fails.
